// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor: 2-bit saturating counters indexed by PC,
// with predictions tracked through ID/EX so they can be checked against the resolved outcome.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int data_size = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_size-1:0] PC_IF,
    input  logic [6:0]           opcode_IF,
    input  logic                 Istall,
    input  logic                 Dstall,
    input  logic                 wfi_stall,
    input  logic                 resolve_valid,
    input  logic                 resolve_taken,
    output logic                 taken_sel,
    output logic                 mispredict,
    output logic [31:0]          branch_cnt,
    output logic [31:0]          miss_cnt
);

    localparam int IW = $clog2(ENTRIES);
    localparam logic [6:0] BTYPE = 7'b1100011;

    logic [1:0]    ctr_table [ENTRIES];
    logic          id_valid, ex_valid;
    logic [IW-1:0] id_idx, ex_idx;
    logic          id_pred, ex_pred;

    logic [IW-1:0] idx_IF;
    logic          is_btype;
    logic          flag_stall;
    logic          commit;
    logic          unused_pc_bits;

    assign idx_IF         = PC_IF[IW+1:2];
    assign unused_pc_bits = ^{PC_IF[data_size-1:IW+2], PC_IF[1:0]};
    assign is_btype       = (opcode_IF == BTYPE);
    assign flag_stall     = Istall | Dstall | wfi_stall;

    // The read at IF sees the table before any update on this edge: no bypass.
    assign taken_sel  = is_btype && ctr_table[idx_IF][1];
    assign mispredict = resolve_valid && ex_valid && (resolve_taken != ex_pred);
    assign commit     = resolve_valid && ex_valid && !flag_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_table[i] <= 2'b01;
            end
            id_valid   <= 1'b0;
            id_idx     <= '0;
            id_pred    <= 1'b0;
            ex_valid   <= 1'b0;
            ex_idx     <= '0;
            ex_pred    <= 1'b0;
            branch_cnt <= 32'd0;
            miss_cnt   <= 32'd0;
        end else if (!flag_stall) begin
            if (commit) begin
                if (resolve_taken) begin
                    if (ctr_table[ex_idx] != 2'b11) begin
                        ctr_table[ex_idx] <= ctr_table[ex_idx] + 2'd1;
                    end
                end else if (ctr_table[ex_idx] != 2'b00) begin
                    ctr_table[ex_idx] <= ctr_table[ex_idx] - 2'd1;
                end
                if (branch_cnt != 32'hFFFF_FFFF) begin
                    branch_cnt <= branch_cnt + 32'd1;
                end
                if (mispredict && (miss_cnt != 32'hFFFF_FFFF)) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
            // A mispredict means IF/ID hold wrong-path instructions, so drop both.
            id_valid <= is_btype && !mispredict;
            id_idx   <= idx_IF;
            id_pred  <= taken_sel;
            ex_valid <= id_valid && !mispredict;
            ex_idx   <= id_idx;
            ex_pred  <= id_pred;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a behavioural model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam logic [6:0] BTYPE = 7'b1100011;
    localparam logic [6:0] JTYPE = 7'b1101111;
    localparam logic [6:0] ITYPE = 7'b0010011;

    logic        clk;
    logic        rst;
    logic [31:0] PC_IF;
    logic [6:0]  opcode_IF;
    logic        Istall, Dstall, wfi_stall;
    logic        resolve_valid, resolve_taken;
    logic        taken_sel, mispredict;
    logic [31:0] branch_cnt, miss_cnt;

    int checks;
    int passes;

    // Reference model: counters as plain integers 0..3, in-flight branches as records.
    typedef struct {
        bit v;
        int idx;
        bit pred;
    } slot_t;

    int          m_ctr [ENTRIES];
    slot_t       m_id, m_ex;
    longint      m_bc, m_mc;

    branch_predictor #(.ENTRIES(ENTRIES), .data_size(32)) dut (
        .clk(clk),
        .rst(rst),
        .PC_IF(PC_IF),
        .opcode_IF(opcode_IF),
        .Istall(Istall),
        .Dstall(Dstall),
        .wfi_stall(wfi_stall),
        .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken),
        .taken_sel(taken_sel),
        .mispredict(mispredict),
        .branch_cnt(branch_cnt),
        .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        m_id = '{v: 0, idx: 0, pred: 0};
        m_ex = '{v: 0, idx: 0, pred: 0};
        m_bc = 0;
        m_mc = 0;
    endfunction

    // Drive one cycle at the negedge, check combinational and counter outputs,
    // then advance the model across the following rising edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [6:0] op, input int stall_sel,
                                 input bit rv, input bit rt, input bit rs);
        bit    exp_taken, exp_mis, stalled, is_b;
        int    idx;
        slot_t new_id;
        @(negedge clk);
        rst           = rs;
        PC_IF         = pc;
        opcode_IF     = op;
        Istall        = (stall_sel == 1);
        Dstall        = (stall_sel == 2);
        wfi_stall     = (stall_sel == 3);
        resolve_valid = rv;
        resolve_taken = rt;
        #1;
        idx       = (pc / 4) % ENTRIES;
        is_b      = (op == BTYPE);
        exp_taken = is_b && (m_ctr[idx] >= 2);
        exp_mis   = rv && m_ex.v && (rt != m_ex.pred);
        stalled   = (stall_sel != 0);
        checkOutput("taken_sel", {31'd0, taken_sel}, {31'd0, exp_taken});
        checkOutput("mispredict", {31'd0, mispredict}, {31'd0, exp_mis});
        checkOutput("branch_cnt", branch_cnt, m_bc[31:0]);
        checkOutput("miss_cnt", miss_cnt, m_mc[31:0]);
        @(posedge clk);
        if (rs) begin
            modelReset();
        end else if (!stalled) begin
            if (rv && m_ex.v) begin
                m_ctr[m_ex.idx] = rt ? ((m_ctr[m_ex.idx] < 3) ? m_ctr[m_ex.idx] + 1 : 3)
                                     : ((m_ctr[m_ex.idx] > 0) ? m_ctr[m_ex.idx] - 1 : 0);
                if (m_bc < 64'hFFFF_FFFF) m_bc++;
                if (exp_mis && m_mc < 64'hFFFF_FFFF) m_mc++;
            end
            new_id = '{v: is_b, idx: idx, pred: exp_taken};
            m_ex   = m_id;
            m_id   = new_id;
            if (exp_mis) begin
                m_ex.v = 0;
                m_id.v = 0;
            end
        end
    endtask

    initial begin
        int op_sel;
        int stall_sel;
        logic [6:0]  op;
        logic [31:0] pc;
        checks        = 0;
        passes        = 0;
        rst           = 1'b1;
        PC_IF         = 32'd0;
        opcode_IF     = 7'd0;
        Istall        = 1'b0;
        Dstall        = 1'b0;
        wfi_stall     = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        modelReset();

        // Reset, then the default weakly-not-taken prediction for a branch at 0x40.
        applyStimulus(32'h40, BTYPE, 0, 0, 0, 1);
        applyStimulus(32'h40, BTYPE, 0, 0, 0, 1);
        applyStimulus(32'h40, BTYPE, 0, 0, 0, 0);

        // Training at 0x40 with every resolution taken, interleaved with aliasing PC 0x80.
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 3 == 2) ? 32'h80 : 32'h40, BTYPE, 0, 1, 1, 0);
        end
        // Hysteresis: resolutions not-taken walk the counter back down.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h40, BTYPE, 0, 1, 0, 0);
        end
        // Stall held with a resolution present: one count on release.
        applyStimulus(32'h40, BTYPE, 0, 1, 1, 0);
        applyStimulus(32'h40, BTYPE, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(32'h40, BTYPE, 2, 1, 1, 0);
        applyStimulus(32'h40, BTYPE, 0, 1, 1, 0);
        // Jump opcode never predicts taken.
        applyStimulus(32'h40, JTYPE, 0, 0, 0, 0);

        // Randomized traffic with aliasing, stalls, flushes and occasional reset.
        for (int i = 0; i < 600; i++) begin
            op_sel = int'($urandom_range(0, 9));
            op     = (op_sel < 6) ? BTYPE : ((op_sel < 8) ? JTYPE : ITYPE);
            pc     = 32'($urandom_range(0, 63)) * 4;
            stall_sel = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(pc, op, stall_sel, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
